// File: rtl/rf_wb_arb_pkg.sv
// Shared widths, default sizes and the writeback entry type for the RF writeback arbiter.
// Latency: none (declarations only). Backpressure: none (declarations only).
// Imported by every rf_wb_arb source file.
package rf_wb_arb_pkg;

  localparam int RF_ADDR_W     = 5;
  localparam int DATA_W        = 32;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int STARVE_LIMIT  = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } wb_ent_t;

endpackage

// File: rtl/rf_wb_arb_wb_fifo.sv
// Multicycle writeback FIFO with per-entry destination compare for operand bypass.
// Latency: push visible at head and in lookups one cycle after the push edge.
// Backpressure: none inside; the caller must never push when full or pop when empty.
module wb_fifo
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  wb_ent_t              push_ent,
  input  logic                 pop,
  output wb_ent_t              head,
  output logic [2:0]           count,
  input  logic [RF_ADDR_W-1:0] look_a_addr,
  input  logic [RF_ADDR_W-1:0] look_b_addr,
  output logic                 look_a_hit,
  output logic [DATA_W-1:0]    look_a_data,
  output logic                 look_b_hit,
  output logic [DATA_W-1:0]    look_b_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_ent_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      slot;
  logic [PW-1:0]    slot_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld    <= '0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    look_a_hit  = 1'b0;
    look_a_data = '0;
    look_b_hit  = 1'b0;
    look_b_data = '0;
    slot        = '0;
    slot_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = {1'b0, rd_ptr} + (PW+1)'(k);
      if (slot >= (PW+1)'(DEPTH)) slot = slot - (PW+1)'(DEPTH);
      slot_idx = slot[PW-1:0];
      if (vld[slot_idx] && mem[slot_idx].addr == look_a_addr) begin
        look_a_hit  = 1'b1;
        look_a_data = mem[slot_idx].data;
      end
      if (vld[slot_idx] && mem[slot_idx].addr == look_b_addr) begin
        look_b_hit  = 1'b1;
        look_b_data = mem[slot_idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter: main pipe has priority, multicycle results queue in a FIFO.
// Latency: pipe write 1 cycle, multicycle write >= 2 cycles. Backpressure: mc_ready from registered
// FIFO count; the pipe is never held, pipe_stall only requests a one-cycle bubble after starvation.
module rf_wb_arb #(
  parameter int DEPTH        = rf_wb_arb_pkg::WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = rf_wb_arb_pkg::STARVE_LIMIT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pipe_we,
  input  logic [rf_wb_arb_pkg::RF_ADDR_W-1:0] pipe_waddr,
  input  logic [rf_wb_arb_pkg::DATA_W-1:0]    pipe_wdata,
  input  logic                               mc_valid,
  output logic                               mc_ready,
  input  logic [rf_wb_arb_pkg::RF_ADDR_W-1:0] mc_waddr,
  input  logic [rf_wb_arb_pkg::DATA_W-1:0]    mc_wdata,
  output logic                               rf_we,
  output logic [rf_wb_arb_pkg::RF_ADDR_W-1:0] rf_waddr,
  output logic [rf_wb_arb_pkg::DATA_W-1:0]    rf_wdata,
  input  logic [rf_wb_arb_pkg::RF_ADDR_W-1:0] fwd_a_addr,
  input  logic [rf_wb_arb_pkg::RF_ADDR_W-1:0] fwd_b_addr,
  output logic                               fwd_a_hit,
  output logic                               fwd_b_hit,
  output logic [rf_wb_arb_pkg::DATA_W-1:0]    fwd_a_data,
  output logic [rf_wb_arb_pkg::DATA_W-1:0]    fwd_b_data,
  output logic                               pipe_stall,
  output logic [2:0]                         fifo_count
);

  import rf_wb_arb_pkg::*;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam int         SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM_C = SW'(STARVE_LIMIT);

  logic            pipe_take;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  wb_ent_t         head;
  logic [SW-1:0]   starve_cnt;
  logic            fa_hit;
  logic            fb_hit;
  logic [DATA_W-1:0] fa_data;
  logic [DATA_W-1:0] fb_data;

  assign mc_ready   = (fifo_count < DEPTH_C);
  assign fifo_empty = (fifo_count == 3'd0);
  assign pipe_take  = pipe_we && (pipe_waddr != '0);
  // Writes to r0 are handshaken but never stored.
  assign push       = mc_valid && mc_ready && (mc_waddr != '0);
  assign pop        = !pipe_take && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_ent    ({mc_waddr, mc_wdata}),
    .pop         (pop),
    .head        (head),
    .count       (fifo_count),
    .look_a_addr (fwd_a_addr),
    .look_b_addr (fwd_b_addr),
    .look_a_hit  (fa_hit),
    .look_a_data (fa_data),
    .look_b_hit  (fb_hit),
    .look_b_data (fb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <= 1'b0;
      if (pipe_take) begin
        rf_we    <= 1'b1;
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= head.addr;
        rf_wdata <= head.data;
      end else begin
        rf_we    <= 1'b0;
      end
      if (pipe_take && !fifo_empty) begin
        if (starve_cnt == LIM_C - SW'(1)) begin
          starve_cnt <= '0;
          pipe_stall <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Queued entries are younger than the output stage, so they win the bypass.
  function automatic logic [DATA_W:0] bypass(
    input logic [RF_ADDR_W-1:0] a,
    input logic                 fhit,
    input logic [DATA_W-1:0]    fdata,
    input logic                 we,
    input logic [RF_ADDR_W-1:0] wa,
    input logic [DATA_W-1:0]    wd
  );
    if (a == '0)          return '0;
    if (fhit)             return {1'b1, fdata};
    if (we && (wa == a))  return {1'b1, wd};
    return '0;
  endfunction

  assign {fwd_a_hit, fwd_a_data} = bypass(fwd_a_addr, fa_hit, fa_data, rf_we, rf_waddr, rf_wdata);
  assign {fwd_b_hit, fwd_b_data} = bypass(fwd_b_addr, fb_hit, fb_data, rf_we, rf_waddr, rf_wdata);

endmodule
